// File: rtl/ram_burst_writer.sv
// ram_burst_writer: burst write controller for a single-port RAM (base + length, valid/ready word stream, address auto-increment with wrap).
// Latency: RAM strobe/address/data are registered, visible the cycle after a beat is accepted; o_done coincides with the last strobe.
// Backpressure: o_data_ready is high only in WRITE; producer gaps stall the burst indefinitely. Optional read-back verify: RAM_BURST_WRITER_VERIFY_EN.
module ram_burst_writer #(
   parameter int SIZE_DATA = 8,
   parameter int SIZE_ADDR = 4,
   parameter int ADDR_STEP = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [SIZE_ADDR-1:0] i_base_addr,
   input  logic [SIZE_ADDR:0]   i_len,
   input  logic                 i_data_valid,
   input  logic [SIZE_DATA-1:0] i_data,
   output logic                 o_data_ready,
   output logic                 o_ram_wr_en,
   output logic                 o_ram_rd_en,
   output logic [SIZE_ADDR-1:0] o_ram_addr,
   output logic [SIZE_DATA-1:0] o_ram_data,
   input  logic [SIZE_DATA-1:0] i_ram_data,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [SIZE_ADDR:0]   o_wr_count,
   output logic                 o_err
);

   // Longest legal burst is one full pass over the RAM; longer requests are clamped to it.
   localparam logic [SIZE_ADDR:0]   LEN_MAX = {1'b1, {SIZE_ADDR{1'b0}}};
   localparam logic [SIZE_ADDR:0]   CNT_ONE = {{SIZE_ADDR{1'b0}}, 1'b1};
   // Truncating the step to the address width makes the increment wrap modulo DEPTH for free.
   localparam logic [SIZE_ADDR-1:0] STEP    = ADDR_STEP[SIZE_ADDR-1:0];

`ifdef RAM_BURST_WRITER_VERIFY_EN
   typedef enum logic [2:0] {IDLE, WRITE, DONE, VERIFY_RD, VERIFY_CMP} state_t;
`else
   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
`endif

   state_t               state_q;
   logic [SIZE_ADDR-1:0] addr_q;
   logic [SIZE_ADDR-1:0] addr_d;
   logic [SIZE_ADDR:0]   len_q;
   logic [SIZE_ADDR:0]   len_d;
   logic [SIZE_ADDR:0]   cnt_q;
   logic [SIZE_ADDR:0]   cnt_d;
   logic                 wr_en_q;
   logic [SIZE_ADDR-1:0] ram_addr_q;
   logic [SIZE_DATA-1:0] ram_data_q;
   logic                 busy_q;
   logic                 done_q;
`ifdef RAM_BURST_WRITER_VERIFY_EN
   logic                 rd_en_q;
   logic                 err_q;
   logic                 cmp_pend_q;
`endif

   // Next address, next beat count and clamped request length
   always_comb begin
      addr_d = addr_q + STEP;
      cnt_d  = cnt_q + CNT_ONE;
      len_d  = (i_len > LEN_MAX) ? LEN_MAX : i_len;
   end

   assign o_data_ready = (state_q == WRITE);
   assign o_ram_wr_en  = wr_en_q;
   assign o_ram_addr   = ram_addr_q;
   assign o_ram_data   = ram_data_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_wr_count   = cnt_q;
`ifdef RAM_BURST_WRITER_VERIFY_EN
   assign o_ram_rd_en  = rd_en_q;
   assign o_err        = err_q;
`else
   // Without read-back the RAM read path is idle and its data is not looked at.
   logic unused_ram_data;
   assign unused_ram_data = ^i_ram_data;
   assign o_ram_rd_en     = 1'b0;
   assign o_err           = 1'b0;
`endif

   // Burst FSM with all RAM-side and status outputs registered
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         wr_en_q    <= 1'b0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef RAM_BURST_WRITER_VERIFY_EN
         rd_en_q    <= 1'b0;
         err_q      <= 1'b0;
         cmp_pend_q <= 1'b0;
`endif
      end else begin
         // Strobes are single-cycle unless re-armed below.
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef RAM_BURST_WRITER_VERIFY_EN
         rd_en_q    <= 1'b0;
         cmp_pend_q <= 1'b0;
         // Read data arrives the cycle after the read strobe; ram_data_q still holds the word written.
         if (cmp_pend_q && (i_ram_data != ram_data_q)) begin
            err_q <= 1'b1;
         end
`endif
         case (state_q)
            IDLE: begin
               if (i_start) begin
                  addr_q <= i_base_addr;
                  len_q  <= len_d;
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
`ifdef RAM_BURST_WRITER_VERIFY_EN
                  err_q  <= 1'b0;
`endif
                  if (len_d == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= WRITE;
                  end
               end
            end
            WRITE: begin
               if (i_data_valid) begin
                  wr_en_q    <= 1'b1;
                  ram_addr_q <= addr_q;
                  ram_data_q <= i_data;
                  addr_q     <= addr_d;
                  cnt_q      <= cnt_d;
`ifdef RAM_BURST_WRITER_VERIFY_EN
                  state_q    <= VERIFY_RD;
`else
                  // Completion pulse lines up with the last write strobe.
                  if (cnt_d == len_q) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
`endif
               end
            end
`ifdef RAM_BURST_WRITER_VERIFY_EN
            VERIFY_RD: begin
               // Write strobe is on the bus this cycle; read the same address next.
               rd_en_q <= 1'b1;
               state_q <= VERIFY_CMP;
            end
            VERIFY_CMP: begin
               cmp_pend_q <= 1'b1;
               if (cnt_q == len_q) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= WRITE;
               end
            end
`endif
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
